// File: rtl/camera_view_mapper_if.sv
// Camera-view bus: scroll/timing/player inputs in, tile-map and sprite coordinates out.
interface camera_view_mapper_if;
    logic [11:0] zeropointx;
    logic        level_restart;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [11:0] ball_x_blue;
    logic [11:0] ball_x_red;
    logic [11:0] cam_x;
    logic [12:0] map_addr;
    logic [3:0]  tile_px_x;
    logic [3:0]  tile_px_y;
    logic        out_of_world;
    logic        map_valid;
    logic [9:0]  blue_screen_x;
    logic [9:0]  red_screen_x;
    logic        blue_visible;
    logic        red_visible;

    // Producer side: scroll controller, VGA timing and player logic.
    modport master (
        output zeropointx, level_restart, frame_start, pix_valid, DrawX, DrawY,
               ball_x_blue, ball_x_red,
        input  cam_x, map_addr, tile_px_x, tile_px_y, out_of_world, map_valid,
               blue_screen_x, red_screen_x, blue_visible, red_visible
    );

    // Mapper side.
    modport slave (
        input  zeropointx, level_restart, frame_start, pix_valid, DrawX, DrawY,
               ball_x_blue, ball_x_red,
        output cam_x, map_addr, tile_px_x, tile_px_y, out_of_world, map_valid,
               blue_screen_x, red_screen_x, blue_visible, red_visible
    );
endinterface

// File: rtl/camera_view_mapper.sv
// Maps screen pixels to tile-map coordinates using a once-per-frame camera origin,
// and maps player world-x into screen-x with visibility flags.
module camera_view_mapper #(
    parameter int unsigned TILE_SHIFT = 4,
    parameter int unsigned MAP_COLS   = 160,
    parameter int unsigned WORLD_W    = 2560,
    parameter int unsigned MAX_SCROLL = 1920,
    parameter int unsigned SCREEN_W   = 640
) (
    input  logic                 Clk,
    input  logic                 Reset,
    camera_view_mapper_if.slave  bus
);
    localparam int unsigned XW  = 12;
    localparam int unsigned YW  = 10;
    localparam int unsigned AW  = 13;
    localparam int unsigned SXW = 10;
    localparam int unsigned TW  = 4;

    logic [XW-1:0]  cam_x_q;
    logic [XW-1:0]  wx1;
    logic [YW-1:0]  y1;
    logic           v1;
    logic [AW-1:0]  map_addr_q;
    logic [TW-1:0]  tile_px_x_q;
    logic [TW-1:0]  tile_px_y_q;
    logic           oow_q;
    logic           map_valid_q;
    logic [SXW-1:0] blue_sx_q;
    logic [SXW-1:0] red_sx_q;
    logic           blue_vis_q;
    logic           red_vis_q;

    logic [AW-1:0]  addr_c;
    logic           oow_c;
    logic [XW-1:0]  blue_d_c;
    logic [XW-1:0]  red_d_c;
    logic           blue_vis_c;
    logic           red_vis_c;

    // Camera origin latch: restart wins, otherwise sample the clamped origin at frame start.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cam_x_q <= '0;
        end else if (bus.level_restart) begin
            cam_x_q <= '0;
        end else if (bus.frame_start) begin
            cam_x_q <= (bus.zeropointx > XW'(MAX_SCROLL)) ? XW'(MAX_SCROLL) : bus.zeropointx;
        end
    end

    // Stage 1: world x of the pixel, computed with the camera origin in force this cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wx1 <= '0;
            y1  <= '0;
            v1  <= 1'b0;
        end else begin
            wx1 <= XW'(bus.DrawX) + cam_x_q;
            y1  <= bus.DrawY;
            v1  <= bus.pix_valid;
        end
    end

    // Stage 2 address arithmetic: row-major tile index, suppressed past the world edge.
    always_comb begin
        oow_c  = (wx1 >= XW'(WORLD_W));
        addr_c = AW'(y1 >> TILE_SHIFT) * AW'(MAP_COLS) + AW'(wx1 >> TILE_SHIFT);
        if (oow_c) begin
            addr_c = '0;
        end
    end

    // Stage 2 register: data updates only for valid pixels, otherwise holds.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            map_addr_q  <= '0;
            tile_px_x_q <= '0;
            tile_px_y_q <= '0;
            oow_q       <= 1'b0;
            map_valid_q <= 1'b0;
        end else begin
            map_valid_q <= v1;
            if (v1) begin
                map_addr_q  <= addr_c;
                tile_px_x_q <= TW'(wx1);
                tile_px_y_q <= TW'(y1);
                oow_q       <= oow_c;
            end
        end
    end

    // Player offsets from the camera; a player left of the camera is never visible.
    always_comb begin
        blue_d_c   = bus.ball_x_blue - cam_x_q;
        red_d_c    = bus.ball_x_red - cam_x_q;
        blue_vis_c = (bus.ball_x_blue >= cam_x_q) && (blue_d_c < XW'(SCREEN_W));
        red_vis_c  = (bus.ball_x_red >= cam_x_q) && (red_d_c < XW'(SCREEN_W));
    end

    // Player screen positions, registered every cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            blue_sx_q  <= '0;
            red_sx_q   <= '0;
            blue_vis_q <= 1'b0;
            red_vis_q  <= 1'b0;
        end else begin
            blue_vis_q <= blue_vis_c;
            red_vis_q  <= red_vis_c;
            blue_sx_q  <= blue_vis_c ? SXW'(blue_d_c) : '0;
            red_sx_q   <= red_vis_c ? SXW'(red_d_c) : '0;
        end
    end

    assign bus.cam_x         = cam_x_q;
    assign bus.map_addr      = map_addr_q;
    assign bus.tile_px_x     = tile_px_x_q;
    assign bus.tile_px_y     = tile_px_y_q;
    assign bus.out_of_world  = oow_q;
    assign bus.map_valid     = map_valid_q;
    assign bus.blue_screen_x = blue_sx_q;
    assign bus.red_screen_x  = red_sx_q;
    assign bus.blue_visible  = blue_vis_q;
    assign bus.red_visible   = red_vis_q;
endmodule

// File: tb/tb_camera_view_mapper.sv
// Scoreboard bench for camera_view_mapper: default world and a narrow-world (2048) copy.
module tb_camera_view_mapper;
    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    camera_view_mapper_if if1 ();
    camera_view_mapper_if if2 ();

    // Narrow-world copy sees exactly the same inputs.
    assign if2.zeropointx    = if1.zeropointx;
    assign if2.level_restart = if1.level_restart;
    assign if2.frame_start   = if1.frame_start;
    assign if2.pix_valid     = if1.pix_valid;
    assign if2.DrawX         = if1.DrawX;
    assign if2.DrawY         = if1.DrawY;
    assign if2.ball_x_blue   = if1.ball_x_blue;
    assign if2.ball_x_red    = if1.ball_x_red;

    camera_view_mapper dut (.Clk(Clk), .Reset(Reset), .bus(if1.slave));
    camera_view_mapper #(.WORLD_W(2048)) dut_narrow (.Clk(Clk), .Reset(Reset), .bus(if2.slave));

    typedef struct packed {
        logic [12:0] addr;
        logic [3:0]  tx;
        logic [3:0]  ty;
        logic        oow;
        int          due;
    } pix_t;

    pix_t q0[$];
    pix_t q1[$];
    int   cyc = 0;
    int   cam_m = 0;
    bit   started = 0;
    int   exp_bsx, exp_rsx;
    bit   exp_bvis, exp_rvis;
    int   n_total = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference pixel mapping in plain integer arithmetic.
    function automatic pix_t model_pix(input int world_w, input int cam, input int dx,
                                       input int dy, input int due);
        pix_t p;
        int wx;
        wx    = dx + cam;
        p.oow = (wx >= world_w);
        p.addr = p.oow ? 13'd0 : 13'((dy / 16) * 160 + wx / 16);
        p.tx  = 4'(wx % 16);
        p.ty  = 4'(dy % 16);
        p.due = due;
        return p;
    endfunction

    // Reference model, advanced at each clock edge using the inputs present at that edge.
    always @(posedge Clk) begin
        int bd, rd;
        cyc++;
        if (!Reset) begin
            q0.delete();
            q1.delete();
            cam_m = 0;
            exp_bsx = 0; exp_rsx = 0; exp_bvis = 0; exp_rvis = 0;
            started = 1;
        end else begin
            if (if1.pix_valid) begin
                q0.push_back(model_pix(2560, cam_m, int'(if1.DrawX), int'(if1.DrawY), cyc + 1));
                q1.push_back(model_pix(2048, cam_m, int'(if1.DrawX), int'(if1.DrawY), cyc + 1));
            end
            bd = int'(if1.ball_x_blue) - cam_m;
            rd = int'(if1.ball_x_red) - cam_m;
            exp_bvis = (bd >= 0) && (bd < 640);
            exp_rvis = (rd >= 0) && (rd < 640);
            exp_bsx  = exp_bvis ? bd : 0;
            exp_rsx  = exp_rvis ? rd : 0;
            if (if1.level_restart) cam_m = 0;
            else if (if1.frame_start) cam_m = (int'(if1.zeropointx) > 1920) ? 1920 : int'(if1.zeropointx);
        end
    end

    // Monitor: compare registered outputs mid-cycle against the model and pixel queues.
    always @(negedge Clk) begin
        pix_t e;
        if (started) begin
            chk("cam_x", 32'(if1.cam_x), 32'(cam_m));
            chk("blue_visible", 32'(if1.blue_visible), 32'(exp_bvis));
            chk("blue_screen_x", 32'(if1.blue_screen_x), 32'(exp_bsx));
            chk("red_visible", 32'(if1.red_visible), 32'(exp_rvis));
            chk("red_screen_x", 32'(if1.red_screen_x), 32'(exp_rsx));
            if (if1.map_valid) begin
                if (q0.size() == 0) chk("pix_spurious", 32'(if1.map_valid), 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("pix_latency", 32'(cyc), 32'(e.due));
                    chk("map_addr", 32'(if1.map_addr), 32'(e.addr));
                    chk("tile_px_x", 32'(if1.tile_px_x), 32'(e.tx));
                    chk("tile_px_y", 32'(if1.tile_px_y), 32'(e.ty));
                    chk("out_of_world", 32'(if1.out_of_world), 32'(e.oow));
                end
            end else if (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front();
                chk("pix_missing", 32'(if1.map_valid), 32'd1);
            end
            if (if2.map_valid) begin
                if (q1.size() == 0) chk("pix2_spurious", 32'(if2.map_valid), 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("pix2_latency", 32'(cyc), 32'(e.due));
                    chk("pix2_map_addr", 32'(if2.map_addr), 32'(e.addr));
                    chk("pix2_tile_px_x", 32'(if2.tile_px_x), 32'(e.tx));
                    chk("pix2_out_of_world", 32'(if2.out_of_world), 32'(e.oow));
                end
            end else if (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                chk("pix2_missing", 32'(if2.map_valid), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        if1.frame_start   = 1'b0;
        if1.level_restart = 1'b0;
        if1.pix_valid     = 1'b0;
    endtask

    task automatic latch(input int zp);
        if1.zeropointx  = 12'(zp);
        if1.frame_start = 1'b1;
        tick();
        if1.frame_start = 1'b0;
    endtask

    task automatic pixel(input int dx, input int dy);
        if1.DrawX     = 10'(dx);
        if1.DrawY     = 10'(dy);
        if1.pix_valid = 1'b1;
        tick();
        if1.pix_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        Reset = 1'b0;
        if1.zeropointx = 12'd100;
        if1.level_restart = 1'b0;
        if1.frame_start = 1'b0;
        if1.pix_valid = 1'b0;
        if1.DrawX = '0;
        if1.DrawY = '0;
        if1.ball_x_blue = 12'd50;
        if1.ball_x_red = 12'd60;

        // Reset held with frame_start pulsing.
        for (int i = 0; i < 3; i++) begin
            if1.frame_start = (i % 2 == 0);
            if1.pix_valid = 1'b1;
            tick();
            chk("reset_cam_x", 32'(if1.cam_x), 32'd0);
            chk("reset_map_valid", 32'(if1.map_valid), 32'd0);
            chk("reset_blue_visible", 32'(if1.blue_visible), 32'd0);
        end
        idle();
        Reset = 1'b1;
        repeat (4) tick();
        chk("post_reset_cam_hold", 32'(if1.cam_x), 32'd0);

        // Frame latch and clamp.
        latch(500);
        chk("latch_500", 32'(if1.cam_x), 32'd500);
        if1.zeropointx = 12'd2000;
        repeat (50) tick();
        chk("hold_500", 32'(if1.cam_x), 32'd500);
        latch(2000);
        chk("clamp_1920", 32'(if1.cam_x), 32'd1920);

        // Pixel mapping latency at cam_x = 500.
        latch(500);
        pixel(37, 35);
        tick();
        chk("dir_map_valid", 32'(if1.map_valid), 32'd1);
        chk("dir_map_addr", 32'(if1.map_addr), 32'd353);
        chk("dir_tile_px_x", 32'(if1.tile_px_x), 32'd9);
        chk("dir_tile_px_y", 32'(if1.tile_px_y), 32'd3);

        // World edge, and past it in the narrow world.
        latch(1920);
        pixel(639, 479);
        tick();
        chk("edge_map_addr", 32'(if1.map_addr), 32'd4799);
        chk("edge_oow", 32'(if1.out_of_world), 32'd0);
        chk("narrow_oow", 32'(if2.out_of_world), 32'd1);
        chk("narrow_addr_zero", 32'(if2.map_addr), 32'd0);

        // Restart beats frame_start; in-flight pixel keeps cam 800.
        latch(800);
        pixel(10, 0);
        if1.zeropointx = 12'd900;
        if1.level_restart = 1'b1;
        if1.frame_start = 1'b1;
        tick();
        idle();
        chk("restart_cam_x", 32'(if1.cam_x), 32'd0);
        chk("restart_inflight_addr", 32'(if1.map_addr), 32'd50);
        chk("restart_inflight_tpx", 32'(if1.tile_px_x), 32'd10);

        // Player visibility boundary.
        latch(500);
        if1.ball_x_blue = 12'd1139;
        if1.ball_x_red = 12'd1140;
        tick();
        chk("blue_edge_vis", 32'(if1.blue_visible), 32'd1);
        chk("blue_edge_x", 32'(if1.blue_screen_x), 32'd639);
        chk("red_past_vis", 32'(if1.red_visible), 32'd0);
        chk("red_past_x", 32'(if1.red_screen_x), 32'd0);
        if1.ball_x_blue = 12'd499;
        tick();
        chk("blue_left_vis", 32'(if1.blue_visible), 32'd0);
        chk("blue_left_x", 32'(if1.blue_screen_x), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 599) != 0);
            if1.pix_valid = ($urandom_range(0, 3) != 0);
            if1.DrawX = 10'($urandom_range(0, 639));
            if1.DrawY = 10'($urandom_range(0, 479));
            if1.frame_start = ($urandom_range(0, 39) == 0);
            if1.level_restart = ($urandom_range(0, 149) == 0);
            if1.zeropointx = 12'($urandom_range(0, 4095));
            r = $urandom_range(0, 5);
            case (r)
                0: if1.ball_x_blue = 12'(cam_m + 639);
                1: if1.ball_x_blue = 12'(cam_m + 640);
                2: if1.ball_x_blue = 12'(cam_m - 1);
                3: if1.ball_x_blue = 12'(cam_m);
                default: if1.ball_x_blue = 12'($urandom_range(0, 4095));
            endcase
            if1.ball_x_red = 12'($urandom_range(0, 4095));
            tick();
        end
        Reset = 1'b1;
        idle();
        repeat (5) tick();
        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/camera_view_mapper.md
Name: camera_view_mapper

Overview:
- Consumer side of the camera-scroll interface. The scroll controller turns player world-x into a camera origin `zeropointx`; this block maps screen pixels back into world/tile coordinates for the background renderer.
- Also converts both player world-x positions into screen-x with visibility flags for the sprite layer.
- Sits between the scroll controller, the VGA timing controller and the tile-map ROM / colour mapper.
- Latches the camera origin once per frame so scrolling never tears mid-frame.

Parameters:
- TILE_SHIFT, 4, log2 of tile edge in pixels (16x16 tiles).
- MAP_COLS, 160, tile columns in the world map.
- WORLD_W, 2560, world width in pixels.
- MAX_SCROLL, 1920, maximum legal camera origin (WORLD_W - SCREEN_W).
- SCREEN_W, 640, visible screen width in pixels.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-low (0 = reset).
- zeropointx  in  12  camera origin from the scroll controller, world pixels.
- level_restart  in  1  high while the game state is "level start" (statenumber == 3'b001).
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  DrawX/DrawY are a visible pixel this cycle.
- DrawX  in  10  screen x, 0..639.
- DrawY  in  10  screen y, 0..479.
- ball_x_blue  in  12  blue player world x.
- ball_x_red  in  12  red player world x.
- cam_x  out  12  frame-latched camera origin.
- map_addr  out  13  tile-map ROM address, row*MAP_COLS + col.
- tile_px_x  out  4  pixel x inside tile.
- tile_px_y  out  4  pixel y inside tile.
- out_of_world  out  1  world x of this pixel >= WORLD_W.
- map_valid  out  1  map_addr/tile_px_*/out_of_world are valid.
- blue_screen_x  out  10  blue player screen x.
- red_screen_x  out  10  red player screen x.
- blue_visible  out  1  blue player is on screen.
- red_visible  out  1  red player is on screen.

Behaviour:
- Reset (Reset == 0 at a Clk edge): every output and internal register goes to 0, including cam_x, the pipeline valids, map_addr, both screen_x outputs and both visible flags.
  - Reset mid-pipeline discards in-flight pixels; map_valid is 0 on the first cycle after reset is released.
- Camera latch, evaluated in priority order each cycle:
  - level_restart = 1: cam_x <= 0 on the next edge, regardless of frame_start.
  - Otherwise, frame_start = 1: cam_x <= min(zeropointx, MAX_SCROLL).
  - Otherwise cam_x holds. zeropointx changes between frame_start pulses have no effect.
- Pixel pipeline: fixed latency of 2 cycles, no stalls; one pixel accepted per cycle.
  - Stage 1 (edge after pix_valid):
    - wx = DrawX + cam_x, 12-bit; cannot overflow because cam_x <= MAX_SCROLL.
    - Register wx, DrawY and v1 = pix_valid.
  - Stage 2 (next edge):
    - map_addr = (DrawY >> TILE_SHIFT) * MAP_COLS + (wx >> TILE_SHIFT), truncated to 13 bits.
    - tile_px_x = wx[3:0], tile_px_y = DrawY[3:0].
    - out_of_world = (wx >= WORLD_W).
    - map_valid = v1.
  - When out_of_world = 1, map_addr is forced to 0.
  - When v1 = 0, map_valid = 0 and the data outputs hold their previous values.
  - The cam_x used for a pixel is the value registered at stage 1. A frame_start landing mid-pipeline affects only pixels entering stage 1 on or after the edge where cam_x updates.
- Player mapping: registered, 1-cycle latency, evaluated every cycle independent of pix_valid. For each player, with d = ball_x - cam_x:
  - If ball_x >= cam_x and d < SCREEN_W: visible = 1, screen_x = d[9:0].
  - Otherwise: visible = 0, screen_x = 0. This covers ball_x < cam_x, where there is no wrap-around use.
  - Boundary: ball_x == cam_x + SCREEN_W - 1 is visible at x = 639; ball_x == cam_x + SCREEN_W is not visible.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset and hold:
  - Stimulus: Reset = 0 for 3 cycles with zeropointx = 100 and frame_start pulsing.
  - Required: cam_x = 0, map_valid = 0, both visible flags = 0 throughout. After release, cam_x stays 0 until the next frame_start.
- Frame latch and clamp:
  - Stimulus: zeropointx = 500, frame_start pulse. Then zeropointx = 2000 with no pulse for 50 cycles. Then a pulse.
  - Required: cam_x = 500, stays 500 through the 50 cycles, then becomes 1920.
- Pixel mapping latency:
  - Stimulus: cam_x = 500; pix_valid = 1 with DrawX = 37, DrawY = 35 at cycle n.
  - Required at cycle n+2: map_valid = 1, wx = 537, map_addr = 2*160 + 33 = 353, tile_px_x = 9, tile_px_y = 3, out_of_world = 0.
- World edge:
  - Stimulus: cam_x = 1920, DrawX = 639, DrawY = 479.
  - Required: wx = 2559, map_addr = 29*160 + 159 = 4799, out_of_world = 0.
  - Also directly test out_of_world = 1 by forcing wx >= 2560 via a parameter override WORLD_W = 2048.
- Restart priority:
  - Stimulus: cam_x = 800; level_restart = 1 and frame_start = 1 in the same cycle, zeropointx = 900.
  - Required: cam_x = 0 on the next cycle. A pixel already in stage 1 still uses wx computed with 800.
- Player visibility:
  - Stimulus: cam_x = 500; blue = 1139, red = 1140; then blue = 499.
  - Required: blue_visible = 1 with blue_screen_x = 639; red_visible = 0 with red_screen_x = 0. Then blue_visible = 0 with blue_screen_x = 0.
